// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, LATENCY
// wait cycles, then a single-cycle response carrying read or merged write data.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   input  logic [3:0]        i_req_be,
   output logic              o_req_ready,
   output logic              o_resp_valid,
   output logic [31:0]       o_resp_rdata
);

   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic [31:0]       r_mem [0:DEPTH-1];

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_f_write;
   logic [ADDR_W-1:0] w_f_addr;
   logic [31:0]       w_f_wdata;
   logic [3:0]        w_f_be;
   logic [31:0]       w_merged;
   logic [31:0]       w_resp_word;

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  be
   );
      logic [31:0] result;
      result = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return result;
   endfunction

   assign w_accept     = i_req_valid & o_req_ready;
   // With zero latency the response is produced straight from the accept edge.
   assign w_enter_resp = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                         ((r_state == ST_IDLE) && w_accept && (LAT == 4'd0));

   // Request fields: live inputs when responding at the accept edge, else latched copy
   always_comb begin
      w_f_write = r_write;
      w_f_addr  = r_addr;
      w_f_wdata = r_wdata;
      w_f_be    = r_be;
      if (r_state == ST_IDLE) begin
         w_f_write = i_req_write;
         w_f_addr  = i_req_addr;
         w_f_wdata = i_req_wdata;
         w_f_be    = i_req_be;
      end else begin
         w_f_write = r_write;
         w_f_addr  = r_addr;
         w_f_wdata = r_wdata;
         w_f_be    = r_be;
      end
   end

   assign w_merged    = merge_bytes(r_mem[w_f_addr], w_f_wdata, w_f_be);
   assign w_resp_word = w_f_write ? w_merged : r_mem[w_f_addr];

   // Storage commit; not reset, and a reset edge drops any pending write
   always_ff @(posedge i_clk) begin
      if (w_enter_resp && w_f_write && !i_rst) begin
         r_mem[w_f_addr] <= w_merged;
      end
   end

   // Request FSM with registered handshake and response outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 32'd0;
         r_be         <= 4'd0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               o_resp_valid <= 1'b0;
               if (w_accept) begin
                  r_write     <= i_req_write;
                  r_addr      <= i_req_addr;
                  r_wdata     <= i_req_wdata;
                  r_be        <= i_req_be;
                  o_req_ready <= 1'b0;
                  if (LAT == 4'd0) begin
                     r_state      <= ST_RESP;
                     o_resp_valid <= 1'b1;
                     o_resp_rdata <= w_resp_word;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= LAT - 4'd1;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state      <= ST_RESP;
                  o_resp_valid <= 1'b1;
                  o_resp_rdata <= w_resp_word;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_state      <= ST_IDLE;
               o_resp_valid <= 1'b0;
               o_req_ready  <= 1'b1;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_cnt        <= 4'd0;
               o_resp_valid <= 1'b0;
               o_req_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random transactions on a LATENCY=2
// instance plus a LATENCY=0 instance, checked against a word-array model.
module tb_dmem_responder;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, write;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        rdy, rv;
   logic [31:0] rd;

   logic        v0, w0;
   logic [7:0]  a0;
   logic [31:0] d0;
   logic [3:0]  b0;
   logic        rdy0, rv0;
   logic [31:0] rd0;

   logic [31:0] mdl  [0:255];
   logic [31:0] mdl0 [0:255];
   logic [31:0] last_exp;
   logic [31:0] last_exp0;
   logic [7:0]  pool [0:15];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(L)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_write(write),
      .i_req_addr(addr), .i_req_wdata(wdata), .i_req_be(be),
      .o_req_ready(rdy), .o_resp_valid(rv), .o_resp_rdata(rd)
   );

   dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(v0), .i_req_write(w0),
      .i_req_addr(a0), .i_req_wdata(d0), .i_req_be(b0),
      .o_req_ready(rdy0), .o_resp_valid(rv0), .o_resp_rdata(rd0)
   );

   function automatic logic [31:0] merge_model(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  en);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++)
         if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction on the LATENCY=2 instance, starting from an idle cycle.
   task automatic txn(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] en, input bit noisy);
      logic [31:0] exp;
      logic [31:0] r;
      @(negedge clk);
      chk("ready_idle", 32'(rdy), 32'd1);
      chk("valid_idle", 32'(rv), 32'd0);
      chk("rdata_hold", rd, last_exp);
      valid = 1'b1; write = wr; addr = a; wdata = wd; be = en;
      if (wr) begin
         exp    = merge_model(mdl[a], wd, en);
         mdl[a] = exp;
      end else begin
         exp = mdl[a];
      end
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clk);
         chk("ready_busy", 32'(rdy), 32'd0);
         chk("resp_strobe", 32'(rv), 32'(k == L + 1));
         if (k == L + 1) chk("resp_data", rd, exp);
         if (noisy) begin
            r = $urandom;
            valid = 1'b1; write = r[0]; addr = r[15:8]; be = r[7:4];
            wdata = $urandom;
         end else begin
            valid = 1'b0;
         end
      end
      valid    = 1'b0;
      last_exp = exp;
   endtask

   // One transaction on the LATENCY=0 instance; response lands one cycle after accept.
   task automatic txn0(input logic wr, input logic [7:0] a, input logic [31:0] wd);
      logic [31:0] exp;
      @(negedge clk);
      chk("l0_ready_idle", 32'(rdy0), 32'd1);
      chk("l0_valid_idle", 32'(rv0), 32'd0);
      chk("l0_rdata_hold", rd0, last_exp0);
      v0 = 1'b1; w0 = wr; a0 = a; d0 = wd; b0 = 4'hF;
      if (wr) begin
         exp     = wd;
         mdl0[a] = wd;
      end else begin
         exp = mdl0[a];
      end
      @(negedge clk);
      v0 = 1'b0;
      chk("l0_ready_busy", 32'(rdy0), 32'd0);
      chk("l0_resp_strobe", 32'(rv0), 32'd1);
      chk("l0_resp_data", rd0, exp);
      last_exp0 = exp;
   endtask

   initial begin
      logic [31:0] r;
      rst = 1'b1;
      valid = 1'b0; write = 1'b0; addr = 8'd0; wdata = 32'd0; be = 4'd0;
      v0 = 1'b0; w0 = 1'b0; a0 = 8'd0; d0 = 32'd0; b0 = 4'd0;
      last_exp = 32'd0; last_exp0 = 32'd0;
      for (int i = 0; i < 16; i++) pool[i] = 8'(i * 17);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state held while idle
      repeat (3) begin
         @(negedge clk);
         chk("rst_ready", 32'(rdy), 32'd1);
         chk("rst_valid", 32'(rv), 32'd0);
         chk("rst_rdata", rd, 32'd0);
         chk("rst_ready0", 32'(rdy0), 32'd1);
      end

      txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      chk("t2_write_word", rd, 32'hDEADBEEF);
      txn(1'b0, 8'h10, 32'd0, 4'h0, 1'b0);
      chk("t2_read_word", rd, 32'hDEADBEEF);

      txn(1'b1, 8'h10, 32'h11223344, 4'b0101, 1'b0);
      chk("t3_merge", rd, 32'hDE22BE44);
      txn(1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
      chk("t3_be_zero", rd, 32'hDE22BE44);
      txn(1'b0, 8'h10, 32'd0, 4'h0, 1'b1);
      chk("t4_noisy_read", rd, 32'hDE22BE44);

      for (int i = 0; i < 16; i++) txn(1'b1, pool[i], $urandom, 4'hF, 1'b0);
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         txn(r[0], pool[r[11:8]], $urandom, r[7:4], r[1]);
      end

      // write to 8'hFF aborted by reset one cycle after accept
      @(negedge clk);
      chk("t5_ready", 32'(rdy), 32'd1);
      valid = 1'b1; write = 1'b1; addr = 8'hFF; wdata = ~mdl[8'hFF]; be = 4'hF;
      @(negedge clk);
      chk("t5_busy", 32'(rdy), 32'd0);
      valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_ready", 32'(rdy), 32'd1);
      chk("t5_rst_valid", 32'(rv), 32'd0);
      chk("t5_rst_rdata", rd, 32'd0);
      last_exp  = 32'd0;
      last_exp0 = 32'd0;
      repeat (4) begin
         @(negedge clk);
         chk("t5_no_resp", 32'(rv), 32'd0);
         chk("t5_idle_ready", 32'(rdy), 32'd1);
      end
      txn(1'b0, 8'hFF, 32'd0, 4'h0, 1'b0);

      // zero-latency instance: seed both ends, then back-to-back reads
      txn0(1'b1, 8'h00, 32'hA5A5_0F0F);
      txn0(1'b1, 8'hFF, 32'h5A5A_F0F0);
      txn0(1'b0, 8'h00, 32'd0);
      txn0(1'b0, 8'hFF, 32'd0);
      @(negedge clk);
      chk("l0_final_ready", 32'(rdy0), 32'd1);
      chk("l0_final_valid", 32'(rv0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
